// File: rtl/bp_pkg.sv
// Shared types for branch resolution: commit/correct records, resolver states,
// and the redirect target helper.
package bp_pkg;

   localparam int         BP_IDX_W     = 6;
   localparam logic [2:0] BR_TYPE_NONE = 3'd0;

   typedef struct packed {
      logic                pred_taken;
      logic                at_mem;
      logic [2:0]          branch_type;
      logic [31:2]         nojpc;
      logic [31:2]         bpc;
      logic [BP_IDX_W-1:0] idx;
   } branch_commit_t;

   typedef struct packed {
      logic                valid;
      logic [BP_IDX_W-1:0] idx;
      logic                taken;
   } branch_correct_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      SQUASH   = 2'd2
   } br_state_e;

   // Word-address target of the real path; no arithmetic by design.
   function automatic logic [31:2] redirect_target(branch_commit_t c, logic taken);
      return taken ? c.bpc : c.nojpc;
   endfunction

endpackage

// File: rtl/branch_hold_reg.sv
// One-entry branch commit buffer with load/clear and a full flag.
// Load wins over clear if both are asserted.
module branch_hold_reg
   import bp_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic           clear,
   input  branch_commit_t d,
   output branch_commit_t q,
   output logic           full
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q    <= '0;
         full <= 1'b0;
      end else if (load) begin
         q    <= d;
         full <= 1'b1;
      end else if (clear) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolver at the EX/MEM boundary: trains the predictor, redirects fetch on
// mispredict and squashes wrong-path commits. Optional counters under BRANCH_STATS_EN.
module branch_resolve
   import bp_pkg::*;
#(
   parameter int IDX_W      = BP_IDX_W,
   parameter int SQUASH_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  branch_commit_t   ex_commit,
   input  logic             ex_id_taken,
   input  logic             mem_taken,
   output logic             ex_ready,
   output logic             upd_valid,
   output logic [IDX_W-1:0] upd_idx,
   output logic             upd_taken,
   output logic             redirect_valid,
   output logic [31:2]      redirect_pc
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]      stat_resolved,
   output logic [31:0]      stat_mispredict
`endif
);

   localparam int CNT_W = (SQUASH_CYC < 2) ? 1 : $clog2(SQUASH_CYC + 1);

   br_state_e       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic            pend_load, pend_clear, pend_full;
   branch_commit_t  pend_d, pend_q;
   logic            hold_load, hold_clear, hold_full;
   branch_commit_t  hold_q;
   logic            hold_taken_reg, hold_taken_next;

   logic            accept;
   logic            res_fire, res_taken, mispredict;
   branch_commit_t  res_c;
   branch_correct_t correct_reg, correct_next;
   logic            redirect_next;
   logic [31:2]     redirect_pc_next;

   branch_hold_reg u_pending (
      .clk   (clk),
      .rst   (rst),
      .load  (pend_load),
      .clear (pend_clear),
      .d     (pend_d),
      .q     (pend_q),
      .full  (pend_full)
   );

   branch_hold_reg u_hold (
      .clk   (clk),
      .rst   (rst),
      .load  (hold_load),
      .clear (hold_clear),
      .d     (ex_commit),
      .q     (hold_q),
      .full  (hold_full)
   );

   assign ex_ready = !hold_full;
   assign accept   = ex_valid && ex_ready && (ex_commit.branch_type != BR_TYPE_NONE);

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      pend_load       = 1'b0;
      pend_clear      = 1'b0;
      pend_d          = ex_commit;
      hold_load       = 1'b0;
      hold_clear      = 1'b0;
      hold_taken_next = hold_taken_reg;
      res_fire        = 1'b0;
      res_c           = ex_commit;
      res_taken       = ex_id_taken;

      case (state_reg)
         IDLE: begin
            if (hold_full) begin
               // A deferred younger branch drains before any new commit is taken.
               hold_clear = 1'b1;
               if (hold_q.at_mem) begin
                  pend_load  = 1'b1;
                  pend_d     = hold_q;
                  state_next = WAIT_MEM;
               end else begin
                  res_fire  = 1'b1;
                  res_c     = hold_q;
                  res_taken = hold_taken_reg;
               end
            end else if (accept) begin
               if (ex_commit.at_mem) begin
                  pend_load  = 1'b1;
                  state_next = WAIT_MEM;
               end else begin
                  res_fire = 1'b1;
               end
            end
         end
         WAIT_MEM: begin
            state_next = IDLE;
            if (pend_full) begin
               res_fire   = 1'b1;
               res_c      = pend_q;
               res_taken  = mem_taken;
               pend_clear = 1'b1;
               // Younger commit survives only when the older one was predicted right.
               if (accept && (mem_taken == pend_q.pred_taken)) begin
                  hold_load       = 1'b1;
                  hold_taken_next = ex_id_taken;
               end
            end
         end
         SQUASH: begin
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg <= CNT_W'(1)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      mispredict = res_fire && (res_taken != res_c.pred_taken);
      if (mispredict) begin
         state_next = SQUASH;
         cnt_next   = CNT_W'(SQUASH_CYC);
      end

      correct_next.valid = res_fire;
      correct_next.idx   = res_fire ? res_c.idx : '0;
      correct_next.taken = res_fire && res_taken;
      redirect_next      = mispredict;
      redirect_pc_next   = mispredict ? redirect_target(res_c, res_taken) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         hold_taken_reg <= 1'b0;
         correct_reg    <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         hold_taken_reg <= hold_taken_next;
         correct_reg    <= correct_next;
         redirect_valid <= redirect_next;
         redirect_pc    <= redirect_pc_next;
      end
   end

   assign upd_valid = correct_reg.valid;
   assign upd_taken = correct_reg.taken;

   if (IDX_W <= BP_IDX_W) begin : g_idx_narrow
      assign upd_idx = correct_reg.idx[IDX_W-1:0];
   end else begin : g_idx_wide
      assign upd_idx = {{(IDX_W - BP_IDX_W){1'b0}}, correct_reg.idx};
   end

`ifdef BRANCH_STATS_EN
   logic [1:0] stat_event;
   assign stat_event = {mispredict, res_fire};

   for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      logic [31:0] cnt_reg;
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_reg <= '0;
         end else if (stat_event[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
            cnt_reg <= cnt_reg + 32'd1;
         end
      end
   end

   assign stat_resolved   = g_stat[0].cnt_reg;
   assign stat_mispredict = g_stat[1].cnt_reg;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_branch_resolve;
   import bp_pkg::*;

   localparam int SQ = 2;

   logic           clk;
   logic           rst;
   logic           ex_valid;
   branch_commit_t ex_commit;
   logic           ex_id_taken;
   logic           mem_taken;
   logic           ex_ready;
   logic           upd_valid;
   logic [5:0]     upd_idx;
   logic           upd_taken;
   logic           redirect_valid;
   logic [31:2]    redirect_pc;
`ifdef BRANCH_STATS_EN
   logic [31:0]    stat_resolved;
   logic [31:0]    stat_mispredict;
`endif

   int total = 0;
   int bad   = 0;

   branch_resolve #(.IDX_W(6), .SQUASH_CYC(SQ)) dut (
      .clk            (clk),
      .rst            (rst),
      .ex_valid       (ex_valid),
      .ex_commit      (ex_commit),
      .ex_id_taken    (ex_id_taken),
      .mem_taken      (mem_taken),
      .ex_ready       (ex_ready),
      .upd_valid      (upd_valid),
      .upd_idx        (upd_idx),
      .upd_taken      (upd_taken),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef BRANCH_STATS_EN
      ,
      .stat_resolved  (stat_resolved),
      .stat_mispredict(stat_mispredict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic uv, input logic [5:0] ui,
                          input logic ut, input logic rv, input logic [29:0] rp);
      chk({tag, "_upd_valid"}, 32'(upd_valid), 32'(uv));
      chk({tag, "_upd_idx"}, 32'(upd_idx), 32'(ui));
      chk({tag, "_upd_taken"}, 32'(upd_taken), 32'(ut));
      chk({tag, "_redirect"}, 32'(redirect_valid), 32'(rv));
      chk({tag, "_redirect_pc"}, 32'(redirect_pc), 32'(rp));
   endtask

   function automatic branch_commit_t mk(input logic pred, input logic at_mem,
                                         input logic [29:0] nojpc, input logic [29:0] bpc,
                                         input logic [5:0] idx);
      branch_commit_t c;
      c.pred_taken  = pred;
      c.at_mem      = at_mem;
      c.branch_type = 3'd1;
      c.nojpc       = nojpc;
      c.bpc         = bpc;
      c.idx         = idx;
      return c;
   endfunction

   task automatic idle(input int n);
      ex_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ex_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Directed single-cycle resolutions from an idle resolver.
   typedef struct {
      logic        pred;
      logic        id_taken;
      logic [5:0]  idx;
      logic [29:0] bpc;
      logic [29:0] nojpc;
      logic        exp_taken;
      logic        exp_redir;
      logic [29:0] exp_pc;
   } vec_t;

   // Reference model: accepted branches wait in a queue tagged with the cycle
   // in which their real direction becomes known.
   typedef struct {
      branch_commit_t c;
      logic           id_taken;
      int             due;
   } mitem_t;

   mitem_t      mq[$];
   int          m_squash;
   bit          m_ready;
   logic        e_upd, e_tk, e_red;
   logic [5:0]  e_idx;
   logic [29:0] e_pc;
   int          n_res, n_misp;

   task automatic m_resolve(input branch_commit_t c, input logic actual, output bit misp);
      e_upd = 1'b1;
      e_idx = c.idx;
      e_tk  = actual;
      misp  = (actual != c.pred_taken);
      n_res++;
      if (misp) begin
         e_red = 1'b1;
         e_pc  = actual ? c.bpc : c.nojpc;
         n_misp++;
      end
   endtask

   task automatic m_step(input int cyc);
      bit busy, misp, next_ready;
      mitem_t it;
      busy = 0;
      misp = 0;
      next_ready = 1;
      e_upd = 0; e_idx = '0; e_tk = 0; e_red = 0; e_pc = '0;
      if (m_squash > 0) begin
         m_squash--;
      end else begin
         if (mq.size() > 0) begin
            busy = 1;
            if (mq[0].due == cyc) begin
               it = mq.pop_front();
               m_resolve(it.c, it.c.at_mem ? mem_taken : it.id_taken, misp);
            end
         end
         if (ex_valid && m_ready && ex_commit.branch_type != BR_TYPE_NONE && !misp) begin
            it.c = ex_commit;
            it.id_taken = ex_id_taken;
            if (busy) begin
               it.due = ex_commit.at_mem ? cyc + 2 : cyc + 1;
               mq.push_back(it);
               next_ready = 0;
            end else if (ex_commit.at_mem) begin
               it.due = cyc + 1;
               mq.push_back(it);
            end else begin
               m_resolve(ex_commit, ex_id_taken, misp);
            end
         end
         if (misp) m_squash = SQ;
      end
      m_ready = next_ready;
   endtask

   vec_t vt[6];

   initial begin
      vt[0] = '{1'b1, 1'b1, 6'd5,  30'h0010_0040, 30'h0000_1234, 1'b1, 1'b0, 30'h0};
      vt[1] = '{1'b0, 1'b1, 6'd9,  30'h0010_0040, 30'h0000_2000, 1'b1, 1'b1, 30'h0010_0040};
      vt[2] = '{1'b1, 1'b0, 6'd63, 30'h3FFF_FFFF, 30'h0000_0155, 1'b0, 1'b1, 30'h0000_0155};
      vt[3] = '{1'b0, 1'b0, 6'd0,  30'h0000_0777, 30'h0000_0888, 1'b0, 1'b0, 30'h0};
      vt[4] = '{1'b1, 1'b0, 6'd42, 30'h0000_0001, 30'h3FFF_FFFF, 1'b0, 1'b1, 30'h3FFF_FFFF};
      vt[5] = '{1'b0, 1'b1, 6'd21, 30'h0000_0000, 30'h0ABC_DEF0, 1'b1, 1'b1, 30'h0};

      rst = 1'b1; ex_valid = 1'b0; ex_commit = '0; ex_id_taken = 1'b0; mem_taken = 1'b0;
      do_reset();
      chk("reset_ready", 32'(ex_ready), 32'd1);
      chk_out("reset", 1'b0, 6'd0, 1'b0, 1'b0, 30'h0);

      foreach (vt[i]) begin
         ex_valid = 1'b1;
         ex_commit = mk(vt[i].pred, 1'b0, vt[i].nojpc, vt[i].bpc, vt[i].idx);
         ex_id_taken = vt[i].id_taken;
         tick();
         ex_valid = 1'b0;
         $display("vec %0d: upd=%0b idx=%0d taken=%0b redirect=%0b pc=%0h",
                  i, upd_valid, upd_idx, upd_taken, redirect_valid, redirect_pc);
         chk_out($sformatf("vec%0d", i), 1'b1, vt[i].idx, vt[i].exp_taken,
                 vt[i].exp_redir, vt[i].exp_pc);
         tick();
         chk($sformatf("vec%0d_pulse", i), 32'(redirect_valid), 32'd0);
         idle(SQ);
      end

      // Commits presented during the squash window are discarded.
      ex_valid = 1'b1;
      ex_commit = mk(1'b0, 1'b0, 30'h10, 30'h0010_0040, 6'd3);
      ex_id_taken = 1'b1;
      tick();
      chk("sq_redirect", 32'(redirect_valid), 32'd1);
      ex_commit = mk(1'b1, 1'b0, 30'h11, 30'h22, 6'd7);
      tick();
      chk("sq_drop0", 32'(upd_valid), 32'd0);
      chk("sq_noredir", 32'(redirect_valid), 32'd0);
      tick();
      chk("sq_drop1", 32'(upd_valid), 32'd0);
      tick();
      $display("squash: post-window upd=%0b idx=%0d", upd_valid, upd_idx);
      chk_out("sq_accept", 1'b1, 6'd7, 1'b1, 1'b0, 30'h0);
      idle(2);

      // MEM-resolved mispredict: redirect two cycles after capture.
      ex_valid = 1'b1;
      ex_commit = mk(1'b1, 1'b1, 30'h100, 30'h0000_0400, 6'd17);
      tick();
      chk_out("mem_wait", 1'b0, 6'd0, 1'b0, 1'b0, 30'h0);
      ex_valid = 1'b0; mem_taken = 1'b0;
      tick();
      $display("mem: redirect=%0b pc=%0h", redirect_valid, redirect_pc);
      chk_out("mem_res", 1'b1, 6'd17, 1'b0, 1'b1, 30'h100);
      idle(SQ + 1);

      // Older MEM branch correct, younger held then resolved.
      ex_valid = 1'b1;
      ex_commit = mk(1'b1, 1'b1, 30'h200, 30'h300, 6'd11);
      tick();
      ex_commit = mk(1'b1, 1'b0, 30'h400, 30'h500, 6'd12);
      ex_id_taken = 1'b1; mem_taken = 1'b1;
      chk("hold_ready_before", 32'(ex_ready), 32'd1);
      tick();
      ex_valid = 1'b0;
      $display("hold: first upd idx=%0d ready=%0b", upd_idx, ex_ready);
      chk_out("hold_old", 1'b1, 6'd11, 1'b1, 1'b0, 30'h0);
      chk("hold_ready_stall", 32'(ex_ready), 32'd0);
      tick();
      $display("hold: second upd idx=%0d ready=%0b", upd_idx, ex_ready);
      chk_out("hold_young", 1'b1, 6'd12, 1'b1, 1'b0, 30'h0);
      chk("hold_ready_after", 32'(ex_ready), 32'd1);
      idle(2);

      // Older MEM branch mispredicts: younger dropped.
      ex_valid = 1'b1;
      ex_commit = mk(1'b1, 1'b1, 30'h0AA, 30'h0BB, 6'd33);
      tick();
      ex_commit = mk(1'b0, 1'b0, 30'h0CC, 30'h0DD, 6'd34);
      ex_id_taken = 1'b1; mem_taken = 1'b0;
      tick();
      ex_valid = 1'b0;
      $display("drop: redirect=%0b pc=%0h", redirect_valid, redirect_pc);
      chk_out("drop_old", 1'b1, 6'd33, 1'b0, 1'b1, 30'h0AA);
      chk("drop_ready", 32'(ex_ready), 32'd1);
      tick();
      chk_out("drop_young", 1'b0, 6'd0, 1'b0, 1'b0, 30'h0);
      idle(SQ + 1);

      // Reset while a MEM branch is pending.
      ex_valid = 1'b1;
      ex_commit = mk(1'b1, 1'b1, 30'h123, 30'h456, 6'd44);
      tick();
      ex_valid = 1'b0; mem_taken = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      $display("rst: upd=%0b redirect=%0b ready=%0b", upd_valid, redirect_valid, ex_ready);
      chk_out("rst_mid", 1'b0, 6'd0, 1'b0, 1'b0, 30'h0);
      chk("rst_ready", 32'(ex_ready), 32'd1);
      tick();
      chk_out("rst_after", 1'b0, 6'd0, 1'b0, 1'b0, 30'h0);

      // Randomized run against the reference model.
      do_reset();
      mq.delete();
      m_squash = 0; m_ready = 1; n_res = 0; n_misp = 0;
      for (int t = 0; t < 400; t++) begin
         branch_commit_t c;
         c.pred_taken  = 1'($urandom);
         c.at_mem      = ($urandom_range(0, 2) == 0);
         c.branch_type = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         c.nojpc       = 30'($urandom);
         c.bpc         = 30'($urandom);
         c.idx         = 6'($urandom);
         ex_commit     = c;
         ex_valid      = ($urandom_range(0, 99) < 60);
         ex_id_taken   = 1'($urandom);
         mem_taken     = 1'($urandom);
         chk("rnd_ready", 32'(ex_ready), 32'(m_ready));
         m_step(t);
         tick();
         if (e_upd)
            $display("rnd %0d: upd idx=%0d taken=%0b redirect=%0b", t, e_idx, e_tk, e_red);
         chk_out("rnd", e_upd, e_idx, e_tk, e_red, e_pc);
      end
      ex_valid = 1'b0;
`ifdef BRANCH_STATS_EN
      chk("stat_resolved", stat_resolved, 32'(n_res));
      chk("stat_mispredict", stat_mispredict, 32'(n_misp));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
